type_rule_cfg_ctrl: RTL and testbench

//  Control-plane loader for the per-stage type-lookup rule tables of the parser/deparser pipeline.

---
 rtl/type_rule_cfg_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_type_rule_cfg_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/type_rule_cfg_ctrl.sv
// Control-plane loader for per-stage type-lookup rule tables: assembles rules from a
// 32-bit command stream and drives the shared one-hot rule write-enable and rule bus.

module type_rule_cfg_stage_dec #(
  parameter int RULE_NUM  = 8,
  parameter int STAGE_IDX = 0
) (
  input  logic                wr_one_i,
  input  logic                sweep_i,
  input  logic [7:0]          stage_i,
  input  logic [7:0]          rule_i,
  input  logic [7:0]          sweep_stage_i,
  output logic [RULE_NUM-1:0] wren_o
);
  logic stage_hit, sweep_hit;
  assign stage_hit = wr_one_i && (stage_i == 8'(STAGE_IDX));
  assign sweep_hit = sweep_i && (sweep_stage_i == 8'(STAGE_IDX));

  always_comb begin
    wren_o = '0;
    for (int r = 0; r < RULE_NUM; r++)
      wren_o[r] = (stage_hit && (rule_i == 8'(r))) || sweep_hit;
  end
endmodule

module type_rule_cfg_ctrl #(
  parameter int STAGE_NUM  = 4,
  parameter int RULE_NUM   = 8,
  parameter int RULE_WIDTH = 100   // packed type_rule_t width
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_cfg_valid,
  output logic                          o_cfg_ready,
  input  logic [31:0]                   i_cfg_data,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [1:0]                    o_rsp_status,
  output logic                          o_busy,
  output logic [STAGE_NUM*RULE_NUM-1:0] o_rule_wren,
  output logic [RULE_WIDTH-1:0]         o_type_rule
);
  localparam int NBEAT = (RULE_WIDTH + 31) / 32;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int SW    = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;

  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_INVAL = 4'd2;
  localparam logic [3:0] OP_CLEAR = 4'd3;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_BADADR = 2'd1;
  localparam logic [1:0] ST_BADOP  = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WR, S_SWEEP, S_RESP} state_e;

  state_e                             state_q, state_d;
  logic [BW-1:0]                      beat_q, beat_d;
  logic [NBEAT*32-1:0]                buf_q, buf_d;
  logic [7:0]                         stage_q, stage_d;
  logic [7:0]                         rule_q, rule_d;
  logic [1:0]                         status_q, status_d;
  logic [SW-1:0]                      sweep_q, sweep_d;
  logic [RULE_WIDTH-1:0]              trule_q, trule_d;
  logic                               ready_q, ready_d;
  logic [STAGE_NUM-1:0][RULE_NUM-1:0] wren_q, wren_d;
  logic                               wr_one, sweep_en;

  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{i_cfg_data[27:24], i_cfg_data[7:0]};

  function automatic logic addr_ok(input logic [7:0] s, input logic [7:0] r);
    return ({1'b0, s} < 9'(STAGE_NUM)) && ({1'b0, r} < 9'(RULE_NUM));
  endfunction

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    buf_d    = buf_q;
    stage_d  = stage_q;
    rule_d   = rule_q;
    status_d = status_q;
    sweep_d  = sweep_q;
    trule_d  = trule_q;
    wr_one   = 1'b0;
    sweep_en = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_cfg_valid) begin
        stage_d = i_cfg_data[23:16];
        rule_d  = i_cfg_data[15:8];
        beat_d  = '0;
        unique case (i_cfg_data[31:28])
          OP_WRITE: state_d = S_DATA;
          OP_INVAL: begin
            if (addr_ok(i_cfg_data[23:16], i_cfg_data[15:8])) begin
              state_d  = S_WR;
              status_d = ST_OK;
              trule_d  = '0;
              wr_one   = 1'b1;
            end else begin
              state_d  = S_RESP;
              status_d = ST_BADADR;
            end
          end
          OP_CLEAR: begin
            state_d  = S_SWEEP;
            status_d = ST_OK;
            sweep_d  = '0;
            trule_d  = '0;
            sweep_en = 1'b1;
          end
          default: begin
            state_d  = S_RESP;
            status_d = ST_BADOP;
          end
        endcase
      end
      S_DATA: if (i_cfg_valid) begin
        buf_d[32*beat_q +: 32] = i_cfg_data;
        if (beat_q == BW'(NBEAT-1)) begin
          // Out-of-range WRITE still drains every beat so the stream stays framed.
          if (addr_ok(stage_q, rule_q)) begin
            state_d  = S_WR;
            status_d = ST_OK;
            trule_d  = buf_d[RULE_WIDTH-1:0];
            wr_one   = 1'b1;
          end else begin
            state_d  = S_RESP;
            status_d = ST_BADADR;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_WR: state_d = S_RESP;
      S_SWEEP: begin
        if (sweep_q == SW'(STAGE_NUM-1)) begin
          state_d = S_RESP;
        end else begin
          sweep_d  = sweep_q + 1'b1;
          sweep_en = 1'b1;
        end
      end
      S_RESP: if (i_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE) || (state_d == S_DATA);
  end

  // Enables are decoded from next-state fields so they land registered with the rule data.
  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
    type_rule_cfg_stage_dec #(.RULE_NUM(RULE_NUM), .STAGE_IDX(s)) u_dec (
      .wr_one_i      (wr_one),
      .sweep_i       (sweep_en),
      .stage_i       (stage_d),
      .rule_i        (rule_d),
      .sweep_stage_i (8'(sweep_d)),
      .wren_o        (wren_d[s])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      buf_q    <= '0;
      stage_q  <= '0;
      rule_q   <= '0;
      status_q <= '0;
      sweep_q  <= '0;
      trule_q  <= '0;
      ready_q  <= 1'b0;
      wren_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      buf_q    <= buf_d;
      stage_q  <= stage_d;
      rule_q   <= rule_d;
      status_q <= status_d;
      sweep_q  <= sweep_d;
      trule_q  <= trule_d;
      ready_q  <= ready_d;
      wren_q   <= wren_d;
    end
  end

  assign o_cfg_ready  = ready_q;
  assign o_rsp_valid  = (state_q == S_RESP);
  assign o_rsp_status = status_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_rule_wren  = wren_q;
  assign o_type_rule  = trule_q;
endmodule

// File: tb/tb_type_rule_cfg_ctrl.sv
// Directed bench for type_rule_cfg_ctrl: vector table of commands plus hand sequences
// for latency, sweep, stalls and mid-command reset.

module tb_type_rule_cfg_ctrl;
  localparam int SN = 4, RN = 8, RW = 100, NW = SN * RN;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic [31:0]   cfg_data = '0;
  logic          rsp_valid, rsp_ready = 1'b0, busy;
  logic [1:0]    rsp_status;
  logic [NW-1:0] wren;
  logic [RW-1:0] trule;

  always #5 clk = ~clk;

  type_rule_cfg_ctrl #(.STAGE_NUM(SN), .RULE_NUM(RN), .RULE_WIDTH(RW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_data(cfg_data), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_status(rsp_status), .o_busy(busy), .o_rule_wren(wren), .o_type_rule(trule)
  );

  int total = 0, bad = 0;
  logic [NW-1:0] wq[$];
  logic [RW-1:0] rq[$];

  always @(negedge clk) if (wren != '0) begin
    wq.push_back(wren);
    rq.push_back(trule);
  end

  typedef struct {
    logic [3:0]       op;
    logic [7:0]       st, ru;
    logic [31:0]      junk;
    logic [3:0][31:0] b;
    int               nb;
    logic [1:0]       status;
    int               cnt;
    logic [NW-1:0]    wr;
    logic [RW-1:0]    rule;
  } vec_t;

  function automatic vec_t mk(logic [3:0] op, logic [7:0] st, logic [7:0] ru, logic [31:0] junk,
                              logic [3:0][31:0] b, int nb, logic [1:0] status, int cnt,
                              logic [NW-1:0] wr, logic [RW-1:0] rule);
    vec_t v;
    v.op = op; v.st = st; v.ru = ru; v.junk = junk; v.b = b; v.nb = nb;
    v.status = status; v.cnt = cnt; v.wr = wr; v.rule = rule;
    return v;
  endfunction

  function automatic logic [31:0] hdr(logic [3:0] op, logic [7:0] st, logic [7:0] ru);
    return {op, 4'h0, st, ru, 8'h00};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!cfg_ready && n < 100) begin step; n++; end
    if (!cfg_ready) chk("ready_timeout", 0, 1);
    step;
    cfg_valid = 1'b0;
  endtask

  task automatic get_rsp(input string nm, input logic [1:0] exp);
    int n = 0;
    while (!rsp_valid && n < 100) begin step; n++; end
    chk({nm, "_rspv"}, 128'(rsp_valid), 1);
    chk({nm, "_status"}, 128'(rsp_status), 128'(exp));
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk({nm, "_idle"}, 128'(busy), 0);
  endtask

  vec_t tv[9];

  initial begin
    int q0;
    logic ok;

    tv[0] = mk(4'h1, 8'd2, 8'd5, 32'h0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
               4, 2'd0, 1, 32'h1 << 21, 100'h4_33333333_22222222_11111111);
    tv[1] = mk(4'h2, 8'd0, 8'd7, 32'h0, '0, 0, 2'd0, 1, 32'h1 << 7, '0);
    tv[2] = mk(4'h1, 8'd4, 8'd0, 32'h0, {32'h4, 32'h3, 32'h2, 32'h1}, 4, 2'd1, 0, '0, '0);
    tv[3] = mk(4'hF, 8'd0, 8'd0, 32'h0, '0, 0, 2'd2, 0, '0, '0);
    tv[4] = mk(4'h1, 8'd3, 8'd7, 32'h0, {32'hFFFFFFFF, 32'hDEADBEEF, 32'h5A5A5A5A, 32'hA5A5A5A5},
               4, 2'd0, 1, 32'h1 << 31, 100'hF_DEADBEEF_5A5A5A5A_A5A5A5A5);
    tv[5] = mk(4'h2, 8'd1, 8'd8, 32'h0, '0, 0, 2'd1, 0, '0, '0);
    tv[6] = mk(4'h0, 8'd1, 8'd1, 32'h0, '0, 0, 2'd2, 0, '0, '0);
    tv[7] = mk(4'h1, 8'd0, 8'd0, 32'h0, {32'h4, 32'h3, 32'h2, 32'h1}, 4, 2'd0, 1, 32'h1,
               100'h4_00000003_00000002_00000001);
    tv[8] = mk(4'h2, 8'd2, 8'd0, 32'h0F0000FF, '0, 0, 2'd0, 1, 32'h1 << 16, '0);

    #3;
    chk("rst_wren", 128'(wren), 0);
    chk("rst_rule", 128'(trule), 0);
    chk("rst_rspv", 128'(rsp_valid), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_ready", 128'(cfg_ready), 0);
    #20 rst_n = 1'b1;
    step;

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      q0 = wq.size();
      send(hdr(tv[i].op, tv[i].st, tv[i].ru) | tv[i].junk);
      for (int k = 0; k < tv[i].nb; k++) send(tv[i].b[k]);
      get_rsp(nm, tv[i].status);
      chk({nm, "_wcnt"}, 128'(wq.size() - q0), 128'(tv[i].cnt));
      if (tv[i].cnt == 1 && wq.size() == q0 + 1) begin
        chk({nm, "_wren"}, 128'(wq[q0]), 128'(tv[i].wr));
        chk({nm, "_rule"}, 128'(rq[q0]), 128'(tv[i].rule));
      end
    end

    // WRITE latency: wren right after the last beat, response one cycle later
    send(hdr(4'h1, 8'd2, 8'd5));
    send(32'h11111111); send(32'h22222222); send(32'h33333333); send(32'h44444444);
    chk("wlat_wren", 128'(wren), 128'(32'h1 << 21));
    chk("wlat_rule", 128'(trule), 128'(100'h4_33333333_22222222_11111111));
    chk("wlat_rsp0", 128'(rsp_valid), 0);
    chk("wlat_ready", 128'(cfg_ready), 0);
    step;
    chk("wlat_wren_off", 128'(wren), 0);
    chk("wlat_rule_hold", 128'(trule), 128'(100'h4_33333333_22222222_11111111));
    chk("wlat_rsp1", 128'(rsp_valid), 1);
    get_rsp("wlat", 2'd0);

    // INVAL latency: wren the cycle after the header, rule bus zero
    send(hdr(4'h2, 8'd0, 8'd7));
    chk("ilat_wren", 128'(wren), 128'(32'h1 << 7));
    chk("ilat_rule", 128'(trule), 0);
    step;
    chk("ilat_wren_off", 128'(wren), 0);
    get_rsp("ilat", 2'd0);

    // CLEAR_ALL sweep, starting from a nonzero rule bus
    send(hdr(4'h1, 8'd1, 8'd1));
    send(32'hCAFEF00D); send(32'h1); send(32'h2); send(32'h3);
    get_rsp("pre_clr", 2'd0);
    q0 = wq.size();
    send(hdr(4'h3, 8'hFF, 8'hFF));
    chk("clr_s0", 128'(wren), 128'(32'h000000FF));
    chk("clr_rule", 128'(trule), 0);
    step; chk("clr_s1", 128'(wren), 128'(32'h0000FF00));
    step; chk("clr_s2", 128'(wren), 128'(32'h00FF0000));
    step; chk("clr_s3", 128'(wren), 128'(32'hFF000000));
    step; chk("clr_end", 128'(wren), 0);
    get_rsp("clr", 2'd0);
    chk("clr_wcnt", 128'(wq.size() - q0), 4);

    // Gaps between beats, then response held off while a header waits
    q0 = wq.size();
    send(hdr(4'h1, 8'd1, 8'd3));
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (3) begin
        step;
        if (!cfg_ready || wren != '0 || rsp_valid) ok = 1'b0;
      end
      send(32'h01010101 * (k + 1));
    end
    chk("gap_ok", 128'(ok), 1);
    step;
    cfg_valid = 1'b1;
    cfg_data  = hdr(4'h2, 8'd0, 8'd0);
    ok = 1'b1;
    repeat (10) begin
      if (!rsp_valid || cfg_ready) ok = 1'b0;
      step;
    end
    cfg_valid = 1'b0;
    chk("hold_ok", 128'(ok), 1);
    get_rsp("gap", 2'd0);
    chk("gap_wcnt", 128'(wq.size() - q0), 1);
    if (wq.size() == q0 + 1) begin
      chk("gap_wren", 128'(wq[q0]), 128'(32'h1 << 11));
      chk("gap_rule", 128'(rq[q0]), 128'(100'h4_03030303_02020202_01010101));
    end

    // Reset after two of four data beats
    q0 = wq.size();
    send(hdr(4'h1, 8'd1, 8'd2));
    send(32'hAAAAAAAA); send(32'hBBBBBBBB);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_wren", 128'(wren), 0);
    chk("mrst_rule", 128'(trule), 0);
    chk("mrst_busy", 128'(busy), 0);
    chk("mrst_rspv", 128'(rsp_valid), 0);
    chk("mrst_ready", 128'(cfg_ready), 0);
    #20 rst_n = 1'b1;
    step; step;
    chk("mrst_nowr", 128'(wq.size() - q0), 0);
    send(hdr(4'h1, 8'd3, 8'd1));
    send(32'h10203040); send(32'h50607080); send(32'h90A0B0C0); send(32'hFFFFFFF7);
    get_rsp("post", 2'd0);
    chk("post_wcnt", 128'(wq.size() - q0), 1);
    if (wq.size() == q0 + 1) begin
      chk("post_wren", 128'(wq[q0]), 128'(32'h1 << 25));
      chk("post_rule", 128'(rq[q0]), 128'(100'h7_90A0B0C0_50607080_10203040));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
